ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits,
// odd parity, stop bit, then device ack sampling with a watchdog.
module ps2_host_tx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000 * 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAXC = (INHIBIT_CYC > TIMEOUT_CYC) ?
                        INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [7:0]    data, data_n;
  logic          clk_oe_n, data_oe_n, done_n, err_n;

  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic       clk_s, data_s, fall;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  assign busy     = (state != IDLE);
  assign tx_ready = (state == IDLE) & rst_n;

  // Sync flops reset to the idle-line level so no false edge follows reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data        <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      data        <= data_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    data_n    = data;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          data_n   = tx_data;
          cnt_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = START;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      START: begin
        clk_oe_n = 1'b0;
        cnt_n    = '0;
        idx_n    = '0;
        state_n  = SEND;
      end
      SEND: begin
        if (fall) begin
          cnt_n = '0;
          idx_n = idx + 4'd1;
          unique case (1'b1)
            (idx < 4'd8):  data_oe_n = ~data[idx[2:0]];
            (idx == 4'd8): data_oe_n = ^data;
            default: begin
              data_oe_n = 1'b0;
              state_n   = ACK;
            end
          endcase
        end else if (cnt == TMO_LAST) begin
          err_n     = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACK: begin
        if (fall) begin
          done_n    = ~data_s;
          err_n     = data_s;
          data_oe_n = 1'b0;
          state_n   = WAIT_IDLE;
        end else if (cnt == TMO_LAST) begin
          err_n     = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (clk_s && data_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
